// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register, fetch handshake, issue to decode.
// Branch redirect, halt and misaligned-target fault between instructions.
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   PCALU_IN / PCINC      PC out to the external +2 incrementer, result back
//   IMEM_ADDR/REQ/ACK/DATA instruction memory fetch handshake
//   IR / IR_VALID         instruction register presented to decode
//   DEC_READY             decode consumes IR
//   BR_TAKEN / BR_TARGET  redirect, sampled at the ISSUE handshake
//   HALT                  stop after the current instruction
//   PC / HALTED / FAULT   architectural PC, stopped flag, sticky fault
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] PCALU_IN,
    input  logic [15:0] PCINC,
    output logic [15:0] IMEM_ADDR,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [15:0] IMEM_DATA,
    output logic [15:0] IR,
    output logic        IR_VALID,
    input  logic        DEC_READY,
    input  logic        BR_TAKEN,
    input  logic [15:0] BR_TARGET,
    input  logic        HALT,
    output logic [15:0] PC,
    output logic        HALTED,
    output logic        FAULT
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        ISSUE,
        STOP
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] ir, ir_n;
    logic        fault, fault_n;

    // Instructions are halfword aligned; bit 0 of the PC is never set.
    localparam logic [15:0] BOOT_PC = {RESET_PC[15:1], 1'b0};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= BOOT;
            pc    <= BOOT_PC;
            ir    <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        fault_n = fault;
        unique case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (IMEM_ACK) begin
                    ir_n    = IMEM_DATA;
                    pc_n    = PCINC;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (DEC_READY) begin
                    // PC already points past this instruction; a
                    // taken branch overrides it with the aligned target.
                    if (BR_TAKEN) begin
                        pc_n = {BR_TARGET[15:1], 1'b0};
                        if (BR_TARGET[0]) fault_n = 1'b1;
                    end
                    state_n = HALT ? STOP : FETCH;
                end
            end
            STOP: state_n = STOP;
            default: state_n = BOOT;
        endcase
    end

    assign PCALU_IN  = pc;
    assign IMEM_ADDR = pc;
    assign PC        = pc;
    assign IR        = ir;
    assign FAULT     = fault;
    assign IMEM_REQ  = (state == FETCH);
    assign IR_VALID  = (state == ISSUE);
    assign HALTED    = (state == STOP);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: vector table plus scoreboard for the
// PC fetch sequencer; a random-stall sequence uses a small PC model.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] PCALU_IN, PCINC, IMEM_ADDR, IMEM_DATA, IR, BR_TARGET, PC;
    logic        IMEM_REQ, IMEM_ACK, IR_VALID, DEC_READY;
    logic        BR_TAKEN, HALT, HALTED, FAULT;

    pc_fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RST(RST),
        .PCALU_IN(PCALU_IN), .PCINC(PCINC),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
        .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .IR(IR), .IR_VALID(IR_VALID), .DEC_READY(DEC_READY),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .HALT(HALT),
        .PC(PC), .HALTED(HALTED), .FAULT(FAULT)
    );

    // External incrementer.
    assign PCINC = PCALU_IN + 16'd2;

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, ack;
        logic [15:0] data;
        logic        dr, bt;
        logic [15:0] tgt;
        logic        halt;
        logic        req, irv, hlt, flt;
        logic [15:0] pc, ir;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        logic rst, logic ack, logic [15:0] data, logic dr, logic bt,
        logic [15:0] tgt, logic halt, logic req, logic irv,
        logic hlt, logic flt, logic [15:0] pc, logic [15:0] ir);
        vec_t v;
        v.rst = rst; v.ack = ack; v.data = data; v.dr = dr;
        v.bt = bt; v.tgt = tgt; v.halt = halt;
        v.req = req; v.irv = irv; v.hlt = hlt; v.flt = flt;
        v.pc = pc; v.ir = ir;
        return v;
    endfunction

    task automatic chk(string name, int idx,
                       logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h, expected %h",
                     name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push expectation, compare after the edge.
    task automatic apply(vec_t v, int idx);
        vec_t e;
        RST = v.rst; IMEM_ACK = v.ack; IMEM_DATA = v.data;
        DEC_READY = v.dr; BR_TAKEN = v.bt; BR_TARGET = v.tgt;
        HALT = v.halt;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard vec %0d: got empty, expected entry",
                     idx);
        end else begin
            e = sb.pop_front();
            chk("IMEM_REQ",  idx, {15'd0, IMEM_REQ}, {15'd0, e.req});
            chk("IR_VALID",  idx, {15'd0, IR_VALID}, {15'd0, e.irv});
            chk("HALTED",    idx, {15'd0, HALTED},   {15'd0, e.hlt});
            chk("FAULT",     idx, {15'd0, FAULT},    {15'd0, e.flt});
            chk("PC",        idx, PC,        e.pc);
            chk("IMEM_ADDR", idx, IMEM_ADDR, e.pc);
            chk("PCALU_IN",  idx, PCALU_IN,  e.pc);
            chk("IR",        idx, IR,        e.ir);
        end
    endtask

    initial begin
        logic [15:0] m_pc, m_ir, d;
        int          vi;

        RST = 1'b1; IMEM_ACK = 1'b0; IMEM_DATA = '0;
        DEC_READY = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0; HALT = 1'b0;
        @(posedge CLK);
        #1;

        //        rst ack data      dr bt tgt       h  req irv hlt flt pc        ir
        tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,0, 0,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,16'hEEEE,1,0,16'h0000,0, 1,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,16'hA000,1,0,16'h0000,0, 0,1,0,0,16'h0002,16'hA000));
        tbl.push_back(mk(0,1,16'hEEEE,1,0,16'h0000,0, 1,0,0,0,16'h0002,16'hA000));
        tbl.push_back(mk(0,1,16'hA002,1,0,16'h0000,0, 0,1,0,0,16'h0004,16'hA002));
        tbl.push_back(mk(0,1,16'hEEEE,1,0,16'h0000,0, 1,0,0,0,16'h0004,16'hA002));
        tbl.push_back(mk(0,0,16'hBAD0,0,0,16'h0000,0, 1,0,0,0,16'h0004,16'hA002));
        tbl.push_back(mk(0,0,16'hBAD0,0,0,16'h0000,0, 1,0,0,0,16'h0004,16'hA002));
        tbl.push_back(mk(0,0,16'hBAD0,0,0,16'h0000,0, 1,0,0,0,16'h0004,16'hA002));
        tbl.push_back(mk(0,1,16'hA004,0,0,16'h0000,0, 0,1,0,0,16'h0006,16'hA004));
        tbl.push_back(mk(0,1,16'hFFFF,0,1,16'h0300,1, 0,1,0,0,16'h0006,16'hA004));
        tbl.push_back(mk(0,0,16'h0000,1,1,16'h0100,0, 1,0,0,0,16'h0100,16'hA004));
        tbl.push_back(mk(0,1,16'hA100,0,0,16'h0000,0, 0,1,0,0,16'h0102,16'hA100));
        tbl.push_back(mk(0,0,16'h0000,1,0,16'h0000,0, 1,0,0,0,16'h0102,16'hA100));
        tbl.push_back(mk(0,1,16'hA102,0,0,16'h0000,0, 0,1,0,0,16'h0104,16'hA102));
        tbl.push_back(mk(0,0,16'h0000,1,1,16'h0101,0, 1,0,0,1,16'h0100,16'hA102));
        tbl.push_back(mk(0,0,16'h0000,1,1,16'h0200,1, 1,0,0,1,16'h0100,16'hA102));
        tbl.push_back(mk(0,1,16'hA100,0,0,16'h0000,0, 0,1,0,1,16'h0102,16'hA100));
        tbl.push_back(mk(0,0,16'h0000,1,1,16'hFFFE,0, 1,0,0,1,16'hFFFE,16'hA100));
        tbl.push_back(mk(0,1,16'hAFFE,0,0,16'h0000,0, 0,1,0,1,16'h0000,16'hAFFE));
        tbl.push_back(mk(0,0,16'h0000,1,0,16'h0000,0, 1,0,0,1,16'h0000,16'hAFFE));
        tbl.push_back(mk(0,1,16'hB000,0,0,16'h0000,0, 0,1,0,1,16'h0002,16'hB000));
        tbl.push_back(mk(0,0,16'h0000,1,1,16'h0040,1, 0,0,1,1,16'h0040,16'hB000));
        tbl.push_back(mk(0,1,16'h1234,1,1,16'h0000,0, 0,0,1,1,16'h0040,16'hB000));
        tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,0, 0,0,1,1,16'h0040,16'hB000));
        tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,0, 0,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,0, 1,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,16'hC000,0,0,16'h0000,0, 0,1,0,0,16'h0002,16'hC000));
        tbl.push_back(mk(0,0,16'h0000,1,0,16'h0000,0, 1,0,0,0,16'h0002,16'hC000));
        tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,0, 1,0,0,0,16'h0002,16'hC000));
        tbl.push_back(mk(1,1,16'hC002,0,0,16'h0000,0, 0,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,16'hEEEE,0,0,16'h0000,0, 1,0,0,0,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,16'hD000,0,0,16'h0000,0, 0,1,0,0,16'h0002,16'hD000));
        tbl.push_back(mk(0,0,16'h0000,1,0,16'h0000,1, 0,0,1,0,16'h0002,16'hD000));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Random fetch and decode stalls against a simple PC model.
        vi = 100;
        m_pc = 16'h0000;
        m_ir = 16'h0000;
        apply(mk(1,0,16'h0,0,0,16'h0,0, 0,0,0,0,m_pc,m_ir), vi++);
        apply(mk(0,0,16'h0,0,0,16'h0,0, 1,0,0,0,m_pc,m_ir), vi++);
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < int'($urandom_range(0, 3)); s++)
                apply(mk(0,0,16'h0,1,0,16'h0,0, 1,0,0,0,m_pc,m_ir), vi++);
            d = 16'h5000 + 16'(k);
            m_pc = m_pc + 16'd2;
            m_ir = d;
            apply(mk(0,1,d,0,0,16'h0,0, 0,1,0,0,m_pc,m_ir), vi++);
            for (int s = 0; s < int'($urandom_range(0, 2)); s++)
                apply(mk(0,1,16'h0,0,0,16'h0,0, 0,1,0,0,m_pc,m_ir), vi++);
            apply(mk(0,0,16'h0,1,0,16'h0,0, 1,0,0,0,m_pc,m_ir), vi++);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
